// File: rtl/ctrl_unit_dot_product_reader_if.sv
// RAM read port and sample stream of the dot-product reader; imag lanes exist only with CTRL_RD_IMAG_EN.
// master = reader (drives RAM requests and the stream), slave = RAM plus consumer side.
interface ctrl_unit_dot_product_reader_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
);
  logic                  re;
  logic [ADDR_WIDTH-1:0] readAddr;
  logic [DATA_WIDTH-1:0] rdDataReal;
  logic [DATA_WIDTH-1:0] dataReal;
  logic                  valid;
  logic                  ready;
  logic                  last;
`ifdef CTRL_RD_IMAG_EN
  logic [ADDR_WIDTH-1:0] readAddrImag;
  logic [DATA_WIDTH-1:0] rdDataImag;
  logic [DATA_WIDTH-1:0] dataImag;
`endif

  modport master (
`ifdef CTRL_RD_IMAG_EN
    output readAddrImag, dataImag,
    input  rdDataImag,
`endif
    output re, readAddr, dataReal, valid, last,
    input  rdDataReal, ready
  );

  modport slave (
`ifdef CTRL_RD_IMAG_EN
    input  readAddrImag, dataImag,
    output rdDataImag,
`endif
    input  re, readAddr, dataReal, valid, last,
    output rdDataReal, ready
  );
endinterface

// File: rtl/ctrl_unit_dot_product_reader.sv
// Walks even table addresses per modulation and streams RAM samples out; CTRL_RD_IMAG_EN adds the imag lane.
// First sample 2 cycles after start; reads stall when buffered + in-flight reaches 2, so ready-low never drops data.
module ctrl_unit_dot_product_reader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [1:0]                         M,
  ctrl_unit_dot_product_reader_if.master     bus,
  output logic                               busy,
  output logic                               done
);

`ifdef CTRL_RD_IMAG_EN
  localparam int EW = 2 * DATA_WIDTH;
`else
  localparam int EW = DATA_WIDTH;
`endif

  typedef struct packed {
    logic          last;
    logic [EW-1:0] dat;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            m_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  at_last;
  logic                  inflight_q;
  logic                  inflight_last_q;
  entry_t                mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;
  entry_t                in_ent;
  entry_t                head;
  logic                  valid;
  logic                  pop;
  logic                  push_st;
  logic                  pop_st;
  logic                  issue;
  logic                  accept;

  always_comb begin
    last_addr = '0;
    case (m_q)
      2'd0: last_addr = '0;
      2'd1: last_addr = ADDR_WIDTH'(6);
      2'd2: last_addr = ADDR_WIDTH'(30);
      2'd3: last_addr = ADDR_WIDTH'(126);
      default: last_addr = '0;
    endcase
  end

  assign at_last = (addr_q == last_addr);

  // The sample arriving from RAM this cycle counts as buffered: it can be
  // presented directly when the buffer is empty, giving valid at T+2.
  always_comb begin
    in_ent.last = inflight_last_q;
`ifdef CTRL_RD_IMAG_EN
    in_ent.dat  = {bus.rdDataImag, bus.rdDataReal};
`else
    in_ent.dat  = bus.rdDataReal;
`endif
  end

  assign head    = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : in_ent;
  assign valid   = (cnt_q != 2'd0) || inflight_q;
  assign pop     = valid && bus.ready;
  assign pop_st  = pop && (cnt_q != 2'd0);
  assign push_st = inflight_q && !(pop && (cnt_q == 2'd0));

  assign bus.valid    = valid;
  assign bus.last     = valid && head.last;
  assign bus.dataReal = valid ? head.dat[DATA_WIDTH-1:0] : '0;
  assign bus.re       = issue;
  assign bus.readAddr = addr_q;
`ifdef CTRL_RD_IMAG_EN
  assign bus.dataImag     = valid ? head.dat[EW-1:DATA_WIDTH] : '0;
  assign bus.readAddrImag = addr_q | ADDR_WIDTH'(1);
`endif

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        busy  = 1'b1;
        issue = ((2'({1'b0, inflight_q}) + cnt_q) < 2'd2);
        if (issue && at_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && head.last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_READ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      m_q             <= 2'd0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state           <= state_nxt;
      inflight_q      <= issue;
      inflight_last_q <= issue && at_last;
      if (accept) begin
        m_q    <= M;
        addr_q <= '0;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_st) begin
        mem_q[wr_ptr_q] <= in_ent;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_st) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push_st) - 2'(pop_st);
    end
  end

endmodule

// File: tb/tb_ctrl_unit_dot_product_reader.sv
// Randomized bench for the dot-product reader: RAM model plus a per-pass expected stream from the modulation table.
module tb_ctrl_unit_dot_product_reader;
  localparam int AW = 7;
  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] M = 2'd0;
  logic       busy, done;

  ctrl_unit_dot_product_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ctrl_unit_dot_product_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [128];
  logic [DW-1:0] ram_q;
  always @(posedge clk) if (bus.re) ram_q <= ram[bus.readAddr];
  assign bus.rdDataReal = ram_q;
  assign bus.ready      = ready;
`ifdef CTRL_RD_IMAG_EN
  logic [DW-1:0] ram_i [128];
  logic [DW-1:0] ram_iq;
  always @(posedge clk) if (bus.re) ram_iq <= ram_i[bus.readAddrImag];
  assign bus.rdDataImag = ram_iq;
`endif

  int total = 0;
  int bad = 0;

  int      rd_addr_q[$];
  int      rd_cyc_q[$];
  int      out_cyc_q[$];
  int      done_cyc_q[$];
  int      out_dat_q[$];
  bit      out_last_q[$];
  int      busy_cnt;
  int      over_issue;
  bit      timed_out;

  function automatic int n_entries(input logic [1:0] m);
    return 1 << (2 * int'(m));
  endfunction

  task automatic fill_ram();
    for (int i = 0; i < 128; i++) begin
      ram[i] = DW'($urandom);
`ifdef CTRL_RD_IMAG_EN
      ram_i[i] = DW'($urandom);
`endif
    end
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low for the first 10 cycles
  task automatic drive(input logic [1:0] m, input int rmode, input bit hold,
                       input bit randm, input int npass);
    int k = 0, issued = 0, xfer = 0, pstart = 0, ndone = 0;
    rd_addr_q.delete(); rd_cyc_q.delete(); out_cyc_q.delete(); done_cyc_q.delete();
    out_dat_q.delete(); out_last_q.delete();
    busy_cnt = 0; over_issue = 0; timed_out = 0;
    forever begin
      @(negedge clk);
      start = (k == 0) || (hold && (ndone < npass - 1 || (k - pstart) < 3));
      M     = (randm && (k - pstart) >= 2 && (k - pstart) <= 10) ? 2'($urandom) : m;
      ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : (k >= 10);
      #1;
      if (busy) busy_cnt++;
      if (bus.re) begin
        if (issued - xfer >= 2) over_issue++;
        rd_addr_q.push_back(int'(bus.readAddr));
        rd_cyc_q.push_back(k);
        issued++;
      end
      if (bus.valid && ready) begin
        out_dat_q.push_back(int'(bus.dataReal));
        out_last_q.push_back(bus.last);
        out_cyc_q.push_back(k);
        xfer++;
      end
      if (done) begin
        done_cyc_q.push_back(k);
        ndone++;
        pstart = k + 1;
      end
      k++;
      if (ndone >= npass && k >= done_cyc_q[$] + 2) break;
      if (k > 1500) begin
        timed_out = 1;
        break;
      end
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total += 7;
    if (bus.re !== 1'b0)       begin bad++; $display("FAIL reset_re got=%b want=0", bus.re); end
    if (bus.readAddr !== '0)   begin bad++; $display("FAIL reset_addr got=%0d want=0", bus.readAddr); end
    if (bus.valid !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    if (bus.last !== 1'b0)     begin bad++; $display("FAIL reset_last got=%b want=0", bus.last); end
    if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0)         begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    if (bus.dataReal !== '0)   begin bad++; $display("FAIL reset_data got=%0d want=0", bus.dataReal); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_qam16();
    fill_ram();
    drive(2'd1, 0, 0, 0, 1);
    total++; if (timed_out) begin bad++; $display("FAIL qam16_timeout got=1 want=0"); end
    total++; if (rd_addr_q.size() != 4) begin bad++; $display("FAIL qam16_nreads got=%0d want=4", rd_addr_q.size()); end
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      total++;
      if (rd_addr_q[i] != 2 * i || rd_cyc_q[i] != i + 1) begin
        bad++; $display("FAIL qam16_read%0d got=addr%0d@%0d want=addr%0d@%0d", i, rd_addr_q[i], rd_cyc_q[i], 2 * i, i + 1);
      end
    end
    total++; if (out_dat_q.size() != 4) begin bad++; $display("FAIL qam16_nsamples got=%0d want=4", out_dat_q.size()); end
    for (int i = 0; i < out_dat_q.size(); i++) begin
      total++;
      if (out_dat_q[i] != int'(ram[2 * i]) || out_cyc_q[i] != i + 2 || out_last_q[i] != (i == 3)) begin
        bad++; $display("FAIL qam16_sample%0d got=%0h@%0d last=%0b want=%0h@%0d last=%0b", i,
                        out_dat_q[i], out_cyc_q[i], out_last_q[i], ram[2 * i], i + 2, (i == 3));
      end
    end
    total++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 6) begin
      bad++; $display("FAIL qam16_done got=%0d pulses first@%0d want=1 pulse @6", done_cyc_q.size(), done_cyc_q[0]);
    end
    total++; if (busy_cnt != 5) begin bad++; $display("FAIL qam16_busy got=%0d want=5", busy_cnt); end
  endtask

  task automatic test_qpsk();
    fill_ram();
    drive(2'd0, 0, 0, 0, 1);
    total++;
    if (timed_out || rd_addr_q.size() != 1 || rd_addr_q[0] != 0 || rd_cyc_q[0] != 1) begin
      bad++; $display("FAIL qpsk_read got=%0d reads first=%0d want=1 read addr0@1", rd_addr_q.size(), rd_addr_q[0]);
    end
    total++;
    if (out_dat_q.size() != 1 || out_dat_q[0] != int'(ram[0]) || !out_last_q[0] || out_cyc_q[0] != 2) begin
      bad++; $display("FAIL qpsk_sample got=%0d samples %0h want=1 sample %0h last@2", out_dat_q.size(), out_dat_q[0], ram[0]);
    end
    total++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 3) begin
      bad++; $display("FAIL qpsk_done got=%0d first@%0d want=1 @3", done_cyc_q.size(), done_cyc_q[0]);
    end
    total++; if (busy_cnt != 2) begin bad++; $display("FAIL qpsk_busy got=%0d want=2", busy_cnt); end
  endtask

  task automatic test_qam256_random();
    fill_ram();
    drive(2'd3, 1, 0, 0, 1);
    total++; if (timed_out) begin bad++; $display("FAIL q256_timeout got=1 want=0"); end
    total++; if (out_dat_q.size() != 64) begin bad++; $display("FAIL q256_nsamples got=%0d want=64", out_dat_q.size()); end
    for (int i = 0; i < out_dat_q.size(); i++) begin
      total++;
      if (out_dat_q[i] != int'(ram[2 * i]) || out_last_q[i] != (i == 63)) begin
        bad++; $display("FAIL q256_sample%0d got=%0h last=%0b want=%0h last=%0b", i, out_dat_q[i], out_last_q[i], ram[2 * i], (i == 63));
      end
    end
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      total++;
      if (rd_addr_q[i] != 2 * i) begin bad++; $display("FAIL q256_addr%0d got=%0d want=%0d", i, rd_addr_q[i], 2 * i); end
    end
    total++; if (over_issue != 0) begin bad++; $display("FAIL q256_overissue got=%0d want=0", over_issue); end
    total++; if (done_cyc_q.size() != 1) begin bad++; $display("FAIL q256_done got=%0d want=1", done_cyc_q.size()); end
  endtask

  task automatic test_back_to_back();
    fill_ram();
    drive(2'd2, 0, 1, 1, 2);
    total++; if (timed_out) begin bad++; $display("FAIL b2b_timeout got=1 want=0"); end
    total++; if (out_dat_q.size() != 32) begin bad++; $display("FAIL b2b_nsamples got=%0d want=32", out_dat_q.size()); end
    for (int i = 0; i < out_dat_q.size(); i++) begin
      total++;
      if (out_dat_q[i] != int'(ram[2 * (i % 16)]) || out_last_q[i] != ((i % 16) == 15)) begin
        bad++; $display("FAIL b2b_sample%0d got=%0h last=%0b want=%0h last=%0b", i, out_dat_q[i], out_last_q[i],
                        ram[2 * (i % 16)], ((i % 16) == 15));
      end
    end
    total++;
    if (done_cyc_q.size() != 2 || rd_addr_q.size() != 32) begin
      bad++; $display("FAIL b2b_passes got=%0d done %0d reads want=2 done 32 reads", done_cyc_q.size(), rd_addr_q.size());
    end else begin
      total++;
      if (rd_cyc_q[16] != done_cyc_q[0] + 1 || out_cyc_q[16] != done_cyc_q[0] + 2 || rd_addr_q[16] != 0) begin
        bad++; $display("FAIL b2b_restart got=re@%0d valid@%0d addr%0d want=re@%0d valid@%0d addr0",
                        rd_cyc_q[16], out_cyc_q[16], rd_addr_q[16], done_cyc_q[0] + 1, done_cyc_q[0] + 2);
      end
    end
  endtask

  task automatic test_reset_midpass();
    int xfer = 0, k = 0, seen = 0;
    fill_ram();
    @(negedge clk);
    M = 2'd2; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (xfer < 5 && k < 100) begin
      #1;
      if (bus.valid && ready) xfer++;
      @(negedge clk);
      k++;
    end
    total++; if (xfer != 5) begin bad++; $display("FAIL rstmid_prefill got=%0d want=5", xfer); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus.re !== 1'b0 || bus.valid !== 1'b0 || bus.last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        bus.dataReal !== '0 || bus.readAddr !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=re%b v%b l%b b%b d%b addr%0d want=all zero",
                      bus.re, bus.valid, bus.last, busy, done, bus.readAddr);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (bus.re || bus.valid || bus.last || done || busy) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_quiet got=%0d active cycles want=0", seen); end
    drive(2'd1, 0, 0, 0, 1);
    total++;
    if (timed_out || rd_addr_q.size() != 4 || rd_addr_q[0] != 0 || out_dat_q.size() != 4 || out_dat_q[0] != int'(ram[0])) begin
      bad++; $display("FAIL rstmid_restart got=%0d reads first addr%0d want=4 reads first addr0", rd_addr_q.size(), rd_addr_q[0]);
    end
  endtask

  task automatic test_ready_stall();
    int early = 0;
    fill_ram();
    drive(2'd2, 2, 0, 0, 1);
    foreach (rd_cyc_q[i]) if (rd_cyc_q[i] < 10) early++;
    total++; if (early != 2) begin bad++; $display("FAIL stall_reads got=%0d want=2", early); end
    total++; if (over_issue != 0) begin bad++; $display("FAIL stall_overissue got=%0d want=0", over_issue); end
    total++;
    if (timed_out || out_dat_q.size() != 16 || out_cyc_q[0] != 10) begin
      bad++; $display("FAIL stall_resume got=%0d samples first@%0d want=16 first@10", out_dat_q.size(), out_cyc_q[0]);
    end
    for (int i = 0; i < out_dat_q.size(); i++) begin
      total++;
      if (out_dat_q[i] != int'(ram[2 * i])) begin bad++; $display("FAIL stall_sample%0d got=%0h want=%0h", i, out_dat_q[i], ram[2 * i]); end
    end
  endtask

  initial begin
    test_reset();
    test_qam16();
    test_qpsk();
    test_qam256_random();
    test_back_to_back();
    test_reset_midpass();
    test_ready_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ctrl_unit_dot_product_reader.md
# ctrl_unit_dot_product_reader

Read-side control unit for the constellation/dot-product buffer. On `start`, it walks the even (real) addresses of the table filled by the write-side controller, issues synchronous RAM reads, and streams the returned real/imag pairs to a downstream consumer (sorter) over a valid/ready handshake. A 2-entry output buffer absorbs the 1-cycle RAM latency so that back-pressure never drops data.

## Interface
Parameters:
- `ADDR_WIDTH`, default 7: RAM address width.
- `DATA_WIDTH`, default 16: width of one real or imag sample.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a read pass; sampled only in IDLE or DONE.
- `M`  in  2  modulation: 00 QPSK, 01 QAM16, 10 QAM64, 11 QAM256; captured at accepted `start`.
- `re`  out  1  RAM read enable.
- `readAddr`  out  ADDR_WIDTH  real address; always even.
- `readAddrImag`  out  ADDR_WIDTH  `readAddr`+1 (present only with `CTRL_RD_IMAG_EN`).
- `rdDataReal`  in  DATA_WIDTH  RAM real data, valid 1 cycle after `re`.
- `rdDataImag`  in  DATA_WIDTH  RAM imag data, same timing (`CTRL_RD_IMAG_EN` only).
- `dataReal`  out  DATA_WIDTH  output sample, real part.
- `dataImag`  out  DATA_WIDTH  output sample, imag part (`CTRL_RD_IMAG_EN` only).
- `valid`  out  1  output sample valid.
- `ready`  in  1  consumer accepts; transfer occurs when `valid && ready`.
- `last`  out  1  qualifies the final sample of the pass.
- `busy`  out  1  high in READ and DRAIN.
- `done`  out  1  one-cycle pulse in DONE.

## Operation
- Entries per pass and last address:
  - QPSK: 1 entry, last address 0.
  - QAM16: 4 entries, last address 6.
  - QAM64: 16 entries, last address 30.
  - QAM256: 64 entries, last address 126.
  - Addresses run 0, 2, 4, … up to and including the last address.
- States:
  - IDLE: on `start`, go to READ; latch `M`; clear the address counter.
  - READ: assert `re` when (buffer occupancy + in-flight reads) < 2.
    - The address counter increments by 2 after each issued read.
    - After the read at the last address is issued, go to DRAIN.
  - DRAIN: no reads. When the `last` sample transfers, go to DONE.
  - DONE: `done`=1 for exactly one cycle.
    - If `start`, go directly to READ with a new pass.
    - Otherwise go to IDLE.
- Output buffer:
  - 2-entry FIFO written from RAM data 1 cycle after `re`.
  - `valid` = FIFO not empty.
  - Head is popped on `valid && ready`.
- `last` is tagged on the entry read from the last address.
- `start` in READ or DRAIN is ignored. `M` changes mid-pass are ignored.
- Reset values: `re`=0, `readAddr`=0, `valid`=0, `last`=0, `busy`=0, `done`=0, data outputs 0. State is IDLE and the FIFO is empty.
- Reset mid-pass discards in-flight reads and buffered data; no `last` or `done` follows.

## Timing
- Cycle T: `start` accepted. Cycle T+1: READ, `re`=1, `readAddr`=0. Cycle T+2: first `valid`.
- With `ready` held high: one read issued and one sample transferred per cycle.
  - QAM16 pass: `re` active T+1..T+4; samples T+2..T+5; `last` at T+5; `done` at T+6.
- QPSK: single read at T+1; `last` at T+2; `done` at T+3.
- `ready` low: `re` stops once 2 entries are held or in flight. No sample is lost or duplicated, and order is preserved.
- Simultaneous push and pop leaves occupancy unchanged.
- `done` to next `valid` is at least 2 cycles (back-to-back `start` in DONE).

## Configuration
- `CTRL_RD_IMAG_EN` defined: the `readAddrImag`, `rdDataImag` and `dataImag` ports exist. The FIFO stores {imag, real}, 2×DATA_WIDTH wide.
- `CTRL_RD_IMAG_EN` undefined: those ports are removed and the FIFO stores real only. Control timing is identical.

## Test plan
- QAM16, `ready`=1: reads at 0, 2, 4, 6; 4 samples on consecutive cycles; `last` on the 4th; `done` 1 cycle later, high for 1 cycle.
- QPSK: exactly one read at address 0 and one sample with `last`=1 → `done`; `busy` high for 2 cycles.
- QAM256 with `ready` toggling randomly: 64 samples in address order 0..126, none dropped or duplicated; `re` never issues with 2 outstanding.
- `start` held continuously with M=QAM64: passes repeat back-to-back via DONE→READ; `start` and `M` changes during READ/DRAIN are ignored.
- `rst` asserted mid-pass (QAM64, after 5 samples): outputs return to reset values immediately; no further `valid`, `last` or `done`; a new `start` begins at address 0.
- `ready`=0 for 10 cycles at pass start: `re` issues exactly 2 reads, then stalls; on release, data resumes in order.
